idu_exu_pipe: RTL and testbench

//  ID->EX pipeline register with operand select and load-use interlock. Captures decoded

---
 rtl/idu_exu_pipe.sv | 142 ++++++++++++++
 tb/tb_idu_exu_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_exu_pipe.sv
// ---------------------------------------------------------------------------
// idu_exu_pipe
//
// ID->EX pipeline register. Captures the decoded instruction from the IDU,
// selects each source operand (forwarded value on a forward hit, otherwise
// register-file read data) and detects the load-use hazard that forwarding
// cannot cover. On that hazard one bubble is inserted while the IDU holds
// its instruction. A flush drops the IDU instruction. A saturating counter
// records the interlock stall cycles.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   idu_valid / idu_ready     IDU handshake (ready = accepted or dropped)
//   idu_pc, idu_inst          instruction PC and raw encoding
//   idu_index_rs1/rs2/rd      register indices
//   idu_use_rs1/rs2           instruction actually reads rs1/rs2
//   idu_wb_en, idu_mem_rd     writes rd / is a load
//   rf_data1/2                register-file read data
//   fw_en1/2, fw_data1/2      forward hit flags and forwarded values
//   flush                     kill the IDU instruction (redirect)
//   exu_ready / exu_valid     EXU handshake
//   exu_pc, exu_inst          registered PC and instruction
//   exu_src1/2                registered operands
//   exu_index_rd, exu_wb_en   registered destination, also to forward unit
//   exu_mem_rd                registered load flag
//   stall_cnt                 load-use stall cycles, saturating
// ---------------------------------------------------------------------------
module idu_exu_pipe #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             idu_valid,
   output logic             idu_ready,
   input  logic [XLEN-1:0]  idu_pc,
   input  logic [31:0]      idu_inst,
   input  logic [4:0]       idu_index_rs1,
   input  logic [4:0]       idu_index_rs2,
   input  logic             idu_use_rs1,
   input  logic             idu_use_rs2,
   input  logic [4:0]       idu_index_rd,
   input  logic             idu_wb_en,
   input  logic             idu_mem_rd,
   input  logic [XLEN-1:0]  rf_data1,
   input  logic [XLEN-1:0]  rf_data2,
   input  logic             fw_en1,
   input  logic             fw_en2,
   input  logic [XLEN-1:0]  fw_data1,
   input  logic [XLEN-1:0]  fw_data2,
   input  logic             flush,
   input  logic             exu_ready,
   output logic             exu_valid,
   output logic [XLEN-1:0]  exu_pc,
   output logic [31:0]      exu_inst,
   output logic [XLEN-1:0]  exu_src1,
   output logic [XLEN-1:0]  exu_src2,
   output logic [4:0]       exu_index_rd,
   output logic             exu_wb_en,
   output logic             exu_mem_rd,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             r_exuValid;
   logic [XLEN-1:0]  r_exuPc;
   logic [31:0]      r_exuInst;
   logic [XLEN-1:0]  r_exuSrc1;
   logic [XLEN-1:0]  r_exuSrc2;
   logic [4:0]       r_exuRd;
   logic             r_exuWbEn;
   logic             r_exuMemRd;
   logic [CNT_W-1:0] r_stallCnt;

   logic             w_advance;
   logic             w_rs1Hit;
   logic             w_rs2Hit;
   logic             w_loadUse;

   // The register can take a new entry when it is empty or being drained.
   // A load in EX produces its data too late for forwarding, so any consumer
   // in the IDU must wait one cycle; x0 is never a real dependency.
   always_comb begin
      w_advance = ~r_exuValid | exu_ready;
      w_rs1Hit  = idu_use_rs1 & (idu_index_rs1 == r_exuRd);
      w_rs2Hit  = idu_use_rs2 & (idu_index_rs2 == r_exuRd);
      w_loadUse = r_exuValid & r_exuMemRd & r_exuWbEn & (r_exuRd != 5'd0) &
                  idu_valid & (w_rs1Hit | w_rs2Hit);
      idu_ready = w_advance & (flush | ~w_loadUse);
   end

   // Pipeline register. Flush beats the interlock, which beats a normal
   // capture. Whenever a bubble is written the writer flags are cleared so
   // the forward unit and the interlock never treat it as a producer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exuValid <= 1'b0;
         r_exuPc    <= '0;
         r_exuInst  <= '0;
         r_exuSrc1  <= '0;
         r_exuSrc2  <= '0;
         r_exuRd    <= '0;
         r_exuWbEn  <= 1'b0;
         r_exuMemRd <= 1'b0;
      end else if (w_advance) begin
         if (flush || w_loadUse) begin
            r_exuValid <= 1'b0;
            r_exuWbEn  <= 1'b0;
            r_exuMemRd <= 1'b0;
         end else begin
            r_exuValid <= idu_valid;
            r_exuPc    <= idu_pc;
            r_exuInst  <= idu_inst;
            r_exuRd    <= idu_index_rd;
            r_exuWbEn  <= idu_valid & idu_wb_en;
            r_exuMemRd <= idu_valid & idu_mem_rd;
            r_exuSrc1  <= fw_en1 ? fw_data1 : rf_data1;
            r_exuSrc2  <= fw_en2 ? fw_data2 : rf_data2;
         end
      end
   end

   // Stall counter: one count per bubble actually inserted by the interlock,
   // sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCnt <= '0;
      end else if (w_advance && w_loadUse && !flush && !(&r_stallCnt)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   assign exu_valid    = r_exuValid;
   assign exu_pc       = r_exuPc;
   assign exu_inst     = r_exuInst;
   assign exu_src1     = r_exuSrc1;
   assign exu_src2     = r_exuSrc2;
   assign exu_index_rd = r_exuRd;
   assign exu_wb_en    = r_exuWbEn;
   assign exu_mem_rd   = r_exuMemRd;
   assign stall_cnt    = r_stallCnt;

endmodule

// File: tb/tb_idu_exu_pipe.sv
// ---------------------------------------------------------------------------
// tb_idu_exu_pipe
//
// Directed bench for idu_exu_pipe. Every accepted instruction pushes its
// expected EX-stage contents into a queue; whenever the DUT shows a valid
// entry the head of the queue is compared, and it is popped once the EXU
// has taken it. Interlock, flush, back-pressure, counter saturation and
// asynchronous reset are exercised as a linear sequence of steps.
// ---------------------------------------------------------------------------
module tb_idu_exu_pipe;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] src1;
      logic [63:0] src2;
      logic [4:0]  rd;
      logic        wb;
      logic        mem;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             idu_valid;
   logic             idu_ready;
   logic [XLEN-1:0]  idu_pc;
   logic [31:0]      idu_inst;
   logic [4:0]       idu_index_rs1;
   logic [4:0]       idu_index_rs2;
   logic             idu_use_rs1;
   logic             idu_use_rs2;
   logic [4:0]       idu_index_rd;
   logic             idu_wb_en;
   logic             idu_mem_rd;
   logic [XLEN-1:0]  rf_data1;
   logic [XLEN-1:0]  rf_data2;
   logic             fw_en1;
   logic             fw_en2;
   logic [XLEN-1:0]  fw_data1;
   logic [XLEN-1:0]  fw_data2;
   logic             flush;
   logic             exu_ready;
   logic             exu_valid;
   logic [XLEN-1:0]  exu_pc;
   logic [31:0]      exu_inst;
   logic [XLEN-1:0]  exu_src1;
   logic [XLEN-1:0]  exu_src2;
   logic [4:0]       exu_index_rd;
   logic             exu_wb_en;
   logic             exu_mem_rd;
   logic [CNT_W-1:0] stall_cnt;

   exp_t sb[$];
   int   errors;
   int   checks;
   int   expStall;

   idu_exu_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .idu_valid(idu_valid), .idu_ready(idu_ready),
      .idu_pc(idu_pc), .idu_inst(idu_inst),
      .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2),
      .idu_use_rs1(idu_use_rs1), .idu_use_rs2(idu_use_rs2),
      .idu_index_rd(idu_index_rd), .idu_wb_en(idu_wb_en), .idu_mem_rd(idu_mem_rd),
      .rf_data1(rf_data1), .rf_data2(rf_data2),
      .fw_en1(fw_en1), .fw_en2(fw_en2), .fw_data1(fw_data1), .fw_data2(fw_data2),
      .flush(flush), .exu_ready(exu_ready), .exu_valid(exu_valid),
      .exu_pc(exu_pc), .exu_inst(exu_inst),
      .exu_src1(exu_src1), .exu_src2(exu_src2),
      .exu_index_rd(exu_index_rd), .exu_wb_en(exu_wb_en), .exu_mem_rd(exu_mem_rd),
      .stall_cnt(stall_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, asserts and reports on a miss.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one IDU instruction; operand sources are derived from the PC so
   // every instruction carries distinguishable data.
   task automatic applyStimulus(input logic v, input logic [63:0] pc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] rd, input logic wb, input logic mem);
      idu_valid     = v;
      idu_pc        = pc;
      idu_inst      = pc[31:0] ^ 32'h0000_0013;
      idu_index_rs1 = rs1;
      idu_index_rs2 = rs2;
      idu_use_rs1   = u1;
      idu_use_rs2   = u2;
      idu_index_rd  = rd;
      idu_wb_en     = wb;
      idu_mem_rd    = mem;
      rf_data1      = pc ^ 64'h1111_0000_0000_1111;
      rf_data2      = pc ^ 64'h2222_0000_0000_2222;
      fw_en1        = 1'b0;
      fw_en2        = 1'b0;
      fw_data1      = ~pc;
      fw_data2      = {pc[31:0], pc[63:32]};
      #1;
   endtask

   // Record what the currently driven instruction must look like in EX.
   task automatic pushExpect();
      exp_t e;
      e.pc   = idu_pc;
      e.inst = idu_inst;
      e.src1 = fw_en1 ? fw_data1 : rf_data1;
      e.src2 = fw_en2 ? fw_data2 : rf_data2;
      e.rd   = idu_index_rd;
      e.wb   = idu_wb_en;
      e.mem  = idu_mem_rd;
      sb.push_back(e);
   endtask

   // Advance one clock; retire the head if the EXU took it, then compare
   // any valid EX entry against the new head.
   task automatic tick();
      logic consumed;
      exp_t e;
      consumed = exu_valid & exu_ready;
      @(posedge clk);
      #1;
      if (consumed && sb.size() != 0) void'(sb.pop_front());
      if (exu_valid) begin
         if (sb.size() == 0) begin
            checkOutput("sb_unexpected_valid", {63'b0, exu_valid}, 64'd0);
         end else begin
            e = sb[0];
            checkOutput("pc",   exu_pc, e.pc);
            checkOutput("inst", {32'b0, exu_inst}, {32'b0, e.inst});
            checkOutput("src1", exu_src1, e.src1);
            checkOutput("src2", exu_src2, e.src2);
            checkOutput("rd",   {59'b0, exu_index_rd}, {59'b0, e.rd});
            checkOutput("wb",   {63'b0, exu_wb_en}, {63'b0, e.wb});
            checkOutput("mem",  {63'b0, exu_mem_rd}, {63'b0, e.mem});
         end
      end
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, "_valid"}, {63'b0, exu_valid}, 64'd0);
      checkOutput({tag, "_wb"},    {63'b0, exu_wb_en}, 64'd0);
      checkOutput({tag, "_mem"},   {63'b0, exu_mem_rd}, 64'd0);
   endtask

   task automatic checkReady(input string tag, input logic expected);
      checkOutput(tag, {63'b0, idu_ready}, {63'b0, expected});
   endtask

   task automatic checkStall(input string tag);
      checkOutput(tag, {60'b0, stall_cnt}, 64'(expStall));
   endtask

   // Directed sequence.
   initial begin
      errors    = 0;
      checks    = 0;
      expStall  = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      exu_ready = 1'b1;
      applyStimulus(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #2;
      checkBubble("reset");
      checkOutput("reset_pc", exu_pc, 64'd0);
      checkOutput("reset_src1", exu_src1, 64'd0);
      checkStall("reset_stall");
      checkReady("reset_ready", 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] independent stream");
      applyStimulus(1'b1, 64'h100, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
      checkReady("stream_ready0", 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h104, 5'd3, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
      checkReady("stream_ready1", 1'b1);
      pushExpect();
      tick();
      checkOutput("stream_valid", {63'b0, exu_valid}, 64'd1);
      checkOutput("stream_pc", exu_pc, 64'h104);
      applyStimulus(1'b0, 64'h108, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      checkBubble("idle");

      $display("[TB] operand select");
      applyStimulus(1'b1, 64'h110, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      rf_data1 = 64'd5;
      fw_en1   = 1'b1;
      fw_data1 = 64'd9;
      pushExpect();
      tick();
      checkOutput("fw_src1_hit", exu_src1, 64'd9);
      applyStimulus(1'b1, 64'h114, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      rf_data1 = 64'd5;
      fw_data1 = 64'd9;
      fw_en2   = 1'b1;
      fw_data2 = 64'hDEAD_BEEF;
      pushExpect();
      tick();
      checkOutput("fw_src1_miss", exu_src1, 64'd5);
      checkOutput("fw_src2_hit", exu_src2, 64'hDEAD_BEEF);

      $display("[TB] load-use interlock");
      applyStimulus(1'b1, 64'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h204, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      checkReady("lu_ready_low", 1'b0);
      tick();
      checkBubble("lu_bubble");
      expStall = 1;
      checkStall("lu_stall1");
      checkReady("lu_ready_retry", 1'b1);
      pushExpect();
      tick();
      checkStall("lu_stall_hold");

      $display("[TB] flush overrides interlock");
      applyStimulus(1'b1, 64'h210, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h214, 5'd0, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      checkReady("flush_lu_ready", 1'b1);
      tick();
      flush = 1'b0;
      checkBubble("flush_lu");
      checkStall("flush_no_count");

      $display("[TB] no-hazard corner cases");
      applyStimulus(1'b1, 64'h300, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h304, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      checkReady("x0_no_stall", 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h308, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      pushExpect();
      tick();
      applyStimulus(1'b1, 64'h30C, 5'd7, 5'd5, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
      checkReady("unused_rs2_no_stall", 1'b1);
      pushExpect();
      tick();
      checkStall("corner_stall");

      $display("[TB] back-pressure and flush");
      applyStimulus(1'b1, 64'h400, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      pushExpect();
      tick();
      exu_ready = 1'b0;
      applyStimulus(1'b1, 64'h404, 5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         flush = (i == 1);
         #1;
         checkReady("bp_ready_low", 1'b0);
         tick();
         checkOutput("bp_hold_pc", exu_pc, 64'h400);
         checkOutput("bp_hold_valid", {63'b0, exu_valid}, 64'd1);
      end
      exu_ready = 1'b1;
      flush     = 1'b1;
      #1;
      checkReady("bp_flush_ready", 1'b1);
      tick();
      flush = 1'b0;
      checkBubble("bp_flush");

      $display("[TB] stall counter saturation");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 64'h500 + 64'(i * 8), 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
         pushExpect();
         tick();
         applyStimulus(1'b1, 64'h504 + 64'(i * 8), 5'd0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
         checkReady("sat_ready_low", 1'b0);
         tick();
         checkBubble("sat_bubble");
         if (expStall < 15) expStall++;
         checkStall("sat_stall");
      end
      checkOutput("sat_max", {60'b0, stall_cnt}, 64'd15);

      $display("[TB] async reset mid-stream");
      applyStimulus(1'b1, 64'h600, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1);
      pushExpect();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkBubble("rst_mid");
      checkOutput("rst_mid_pc", exu_pc, 64'd0);
      checkOutput("rst_mid_rd", {59'b0, exu_index_rd}, 64'd0);
      expStall = 0;
      checkStall("rst_mid_stall");
      sb.delete();
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 64'h700, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
      pushExpect();
      tick();
      checkOutput("post_rst_valid", {63'b0, exu_valid}, 64'd1);
      applyStimulus(1'b0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
